fixed_to_float_arbiter: RTL and testbench

//  Shares one fixed_to_float converter among N_REQ requesters. Arbitration is round-robin.

---
 rtl/fixed_to_float_arbiter_if.sv | 33 +++
 rtl/fixed_to_float_arbiter.sv | 162 ++++++++++++++++
 tb/tb_fixed_to_float_arbiter.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fixed_to_float_arbiter_if.sv
// Bus bundle between requesters, the shared fixed->float converter and the arbiter.
// Every channel is avail/get: a transfer happens on a rising clk edge where avail & get are both 1, and avail holds with stable data until then.
interface fixed_to_float_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int FXD_N = 64,
    parameter int FW    = 64
);
    logic [N_REQ-1:0]       req_avail;
    logic [N_REQ-1:0]       req_get;
    logic [N_REQ*FXD_N-1:0] req_data;

    logic                   cvt_pre_avail;
    logic                   cvt_pre_get;
    logic [FXD_N-1:0]       cvt_pre_data;

    logic                   cvt_post_avail;
    logic                   cvt_post_get;
    logic [FW-1:0]          cvt_post_data;

    logic [N_REQ-1:0]       rsp_avail;
    logic [N_REQ-1:0]       rsp_get;
    logic [FW-1:0]          rsp_data;

    modport master (
        input  req_avail, req_data, cvt_pre_get, cvt_post_avail, cvt_post_data, rsp_get,
        output req_get, cvt_pre_avail, cvt_pre_data, cvt_post_get, rsp_avail, rsp_data
    );

    modport slave (
        output req_avail, req_data, cvt_pre_get, cvt_post_avail, cvt_post_data, rsp_get,
        input  req_get, cvt_pre_avail, cvt_pre_data, cvt_post_get, rsp_avail, rsp_data
    );
endinterface

// File: rtl/fixed_to_float_arbiter.sv
// Round-robin sharing of one in-order fixed->float converter among N_REQ requesters;
// an in-order tag FIFO steers each converter result back to the requester that issued it.
module fixed_to_float_arbiter #(
    parameter  int N_REQ     = 4,
    parameter  int FXD_N     = 64,
    parameter  int FLT_EXP   = 11,
    parameter  int FLT_FRAC  = 52,
    parameter  int TAG_DEPTH = 4,
    localparam int ID_W      = $clog2(N_REQ),
    localparam int FW        = FLT_EXP + FLT_FRAC + 1,
    localparam int PTR_W     = $clog2(TAG_DEPTH),
    localparam int CNT_W     = PTR_W + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    fixed_to_float_arbiter_if.master bus,
    output logic [CNT_W-1:0]     inflight,
    output logic                 err
);

    logic              issue_vld;
    logic [FXD_N-1:0]  issue_data;
    logic [ID_W-1:0]   issue_id;
    logic [ID_W-1:0]   rr_ptr;

    logic [ID_W-1:0]   tag_mem [TAG_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  tag_cnt;

    logic              rsp_vld;
    logic [ID_W-1:0]   rsp_id;
    logic [FW-1:0]     rsp_data_q;

    logic              accept;
    logic              found;
    logic [ID_W:0]     cand;
    logic [ID_W-1:0]   grant_idx;
    logic              pre_hs;
    logic              post_hs;
    logic              rsp_hs;
    logic              rsp_free;
    logic              tag_empty;
    logic              post_orphan;
    logic              push;
    logic              pop;
    logic [ID_W-1:0]   head_id;

    assign inflight  = tag_cnt + CNT_W'(issue_vld);
    assign tag_empty = (tag_cnt == '0);
    assign pre_hs    = issue_vld & bus.cvt_pre_get;

    // rst_n gates the grant so req_get reads 0 during reset even with operands pending.
    assign accept = rst_n & (|bus.req_avail) & (!issue_vld | bus.cvt_pre_get)
                  & (inflight < CNT_W'(TAG_DEPTH));

    // Scan rr_ptr, rr_ptr+1, ... modulo N_REQ; first asserted request wins.
    always_comb begin
        grant_idx = rr_ptr;
        found     = 1'b0;
        cand      = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = {1'b0, rr_ptr} + (ID_W+1)'(k);
            if (cand >= (ID_W+1)'(N_REQ)) begin
                cand = cand - (ID_W+1)'(N_REQ);
            end
            if (!found && bus.req_avail[cand[ID_W-1:0]]) begin
                found     = 1'b1;
                grant_idx = cand[ID_W-1:0];
            end
        end
    end

    always_comb begin
        bus.req_get = '0;
        if (accept) begin
            bus.req_get[grant_idx] = 1'b1;
        end
    end

    assign bus.cvt_pre_avail = issue_vld;
    assign bus.cvt_pre_data  = issue_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_vld  <= 1'b0;
            issue_data <= '0;
            issue_id   <= '0;
            rr_ptr     <= '0;
        end else if (accept) begin
            issue_vld  <= 1'b1;
            issue_data <= bus.req_data[grant_idx*FXD_N +: FXD_N];
            issue_id   <= grant_idx;
            rr_ptr     <= (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end else if (pre_hs) begin
            issue_vld  <= 1'b0;
        end
    end

    // An empty FIFO with a valid issue register means a pass-through converter:
    // its result belongs to issue_id, which is being pushed in this same cycle.
    assign head_id     = tag_empty ? issue_id : tag_mem[rd_ptr];
    assign post_orphan = bus.cvt_post_avail & tag_empty & !issue_vld;
    assign rsp_free    = !rsp_vld | bus.rsp_get[rsp_id];
    assign bus.cvt_post_get = rsp_free & !post_orphan;
    assign post_hs     = bus.cvt_post_avail & bus.cvt_post_get;
    assign rsp_hs      = rsp_vld & bus.rsp_get[rsp_id];
    assign push        = pre_hs;
    assign pop         = post_hs & (!tag_empty | push);

    always_ff @(posedge clk) begin
        if (push) begin
            tag_mem[wr_ptr] <= issue_id;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            tag_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   tag_cnt <= tag_cnt + 1'b1;
                2'b01:   tag_cnt <= tag_cnt - 1'b1;
                default: tag_cnt <= tag_cnt;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_vld    <= 1'b0;
            rsp_id     <= '0;
            rsp_data_q <= '0;
        end else if (post_hs) begin
            rsp_vld    <= 1'b1;
            rsp_id     <= head_id;
            rsp_data_q <= bus.cvt_post_data;
        end else if (rsp_hs) begin
            rsp_vld    <= 1'b0;
        end
    end

    assign bus.rsp_avail = rsp_vld ? (N_REQ'(1) << rsp_id) : '0;
    assign bus.rsp_data  = rsp_data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (post_orphan) begin
            err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fixed_to_float_arbiter.sv
// Directed bench for fixed_to_float_arbiter with a Q32.32 -> double converter model and a result scoreboard.
module tb_fixed_to_float_arbiter;

    localparam int N_REQ = 4;
    localparam int FXD_N = 64;
    localparam int FW    = 64;

    logic       clk;
    logic       rst_n;
    logic [2:0] inflight;
    logic       err;

    fixed_to_float_arbiter_if #(.N_REQ(N_REQ), .FXD_N(FXD_N), .FW(FW)) bus_if ();

    fixed_to_float_arbiter #(
        .N_REQ(N_REQ), .FXD_N(FXD_N), .FLT_EXP(11), .FLT_FRAC(52), .TAG_DEPTH(4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus_if.master),
        .inflight (inflight),
        .err      (err)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- converter model ----------------
    function automatic logic [63:0] to_double(input logic [63:0] x);
        real r;
        r = $signed(x);
        r = r / 4294967296.0;
        return $realtobits(r);
    endfunction

    logic [63:0] conv_mem [16];
    int          conv_wr, conv_rd, conv_cnt;
    logic        pre_hold, post_hold, inject_post;

    assign bus_if.cvt_pre_get    = !pre_hold;
    assign bus_if.cvt_post_avail = (conv_cnt != 0 && !post_hold) || inject_post;
    assign bus_if.cvt_post_data  = (conv_cnt != 0) ? conv_mem[conv_rd % 16] : 64'h0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conv_wr  <= 0;
            conv_rd  <= 0;
            conv_cnt <= 0;
        end else begin
            if (bus_if.cvt_pre_avail && bus_if.cvt_pre_get) begin
                conv_mem[conv_wr % 16] <= to_double(bus_if.cvt_pre_data);
                conv_wr <= conv_wr + 1;
            end
            if (bus_if.cvt_post_avail && bus_if.cvt_post_get && conv_cnt != 0) begin
                conv_rd <= conv_rd + 1;
            end
            conv_cnt <= conv_cnt
                      + ((bus_if.cvt_pre_avail && bus_if.cvt_pre_get) ? 1 : 0)
                      - ((bus_if.cvt_post_avail && bus_if.cvt_post_get && conv_cnt != 0) ? 1 : 0);
        end
    end

    // ---------------- requester / scoreboard state ----------------
    logic [63:0] lane_ops [4][8];
    int          lane_rd [4];
    int          lane_wr [4];
    logic [3:0]  rsp_mask;
    logic        random_stall;
    logic [65:0] exp_q [$];
    logic [63:0] last_lane_data [4];
    int          grant_log [16];
    int          n_grants;
    int          vectors;
    int          miscompares;

    assign bus_if.rsp_get = rsp_mask;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pending_ops();
        int n;
        n = 0;
        for (int i = 0; i < 4; i++) n += lane_wr[i] - lane_rd[i];
        return n;
    endfunction

    task automatic drive_reqs();
        for (int i = 0; i < 4; i++) begin
            bus_if.req_avail[i]          = (lane_rd[i] != lane_wr[i]);
            bus_if.req_data[i*64 +: 64]  = lane_ops[i][lane_rd[i] % 8];
        end
    endtask

    task automatic add_op(input int lane, input logic [63:0] val);
        lane_ops[lane][lane_wr[lane] % 8] = val;
        lane_wr[lane]++;
    endtask

    task automatic clear_tb();
        for (int i = 0; i < 4; i++) lane_rd[i] = lane_wr[i];
        exp_q.delete();
        rsp_mask     = 4'b1111;
        pre_hold     = 1'b0;
        post_hold    = 1'b0;
        inject_post  = 1'b0;
        random_stall = 1'b0;
        n_grants     = 0;
        drive_reqs();
    endtask

    // One clock: sample at negedge, score, then advance requesters just after the edge.
    task automatic cycle();
        logic [3:0]  g, ra, rg;
        logic [63:0] rd;
        logic [65:0] e;
        logic [1:0]  gi;
        @(negedge clk);
        g  = bus_if.req_get;
        ra = bus_if.rsp_avail;
        rg = bus_if.rsp_get;
        rd = bus_if.rsp_data;
        gi = 2'd0;
        if (g != 4'b0) begin
            check("grant_valid", 128'($onehot(g) && ((g & ~bus_if.req_avail) == 4'b0)), 128'(1));
            for (int i = 0; i < 4; i++) if (g[i]) gi = 2'(i);
            if (n_grants < 16) grant_log[n_grants] = int'(gi);
            n_grants++;
            exp_q.push_back({gi, to_double(lane_ops[gi][lane_rd[gi] % 8])});
        end
        if ((ra & rg) != 4'b0) begin
            if (exp_q.size() == 0) begin
                check("rsp_unexpected", 128'(ra), 128'(0));
            end else begin
                e = exp_q.pop_front();
                check("rsp_route", 128'(ra), 128'(4'b0001 << e[65:64]));
                check("rsp_data", 128'(rd), 128'(e[63:0]));
                last_lane_data[e[65:64]] = rd;
            end
        end
        @(posedge clk);
        #1;
        if (g != 4'b0) lane_rd[gi]++;
        drive_reqs();
        pre_hold = random_stall ? ($urandom_range(0, 3) == 0) : 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 300 && (exp_q.size() != 0 || pending_ops() != 0); i++) cycle();
        check({tag, "_drain"}, 128'(exp_q.size() + pending_ops()), 128'(0));
        check({tag, "_inflight"}, 128'(inflight), 128'(0));
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_req_get"}, 128'(bus_if.req_get), 128'(0));
        check({tag, "_pre_avail"}, 128'(bus_if.cvt_pre_avail), 128'(0));
        check({tag, "_post_get"}, 128'(bus_if.cvt_post_get), 128'(1));
        check({tag, "_rsp_avail"}, 128'(bus_if.rsp_avail), 128'(0));
        check({tag, "_inflight"}, 128'(inflight), 128'(0));
        check({tag, "_err"}, 128'(err), 128'(0));
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        clear_tb();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed sequence ----------------
    logic [63:0] held;

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        for (int i = 0; i < 4; i++) begin
            lane_rd[i] = 0;
            lane_wr[i] = 0;
            last_lane_data[i] = '0;
        end
        bus_if.req_avail = '0;
        bus_if.req_data  = '0;
        clear_tb();
        #3;
        check_reset("por");
        apply_reset();

        // T1 single operand, 1.0 in Q32.32
        add_op(2, 64'h0000_0001_0000_0000);
        drive_reqs();
        #1;
        check("t1_grant", 128'(bus_if.req_get), 128'(4'b0100));
        drain("t1");
        check("t1_value", 128'(last_lane_data[2]), 128'(64'h3FF0_0000_0000_0000));

        // T2 fairness with random converter-input stalls
        apply_reset();
        random_stall = 1'b1;
        for (int r = 0; r < 2; r++)
            for (int l = 0; l < 4; l++) add_op(l, {$urandom, $urandom});
        drive_reqs();
        drain("t2");
        check("t2_grants", 128'(n_grants), 128'(8));
        for (int k = 0; k < 8; k++) check("t2_order", 128'(grant_log[k]), 128'(k % 4));

        // T3 converter output backpressure caps inflight at TAG_DEPTH
        apply_reset();
        post_hold = 1'b1;
        for (int l = 0; l < 4; l++) add_op(l, {$urandom, $urandom});
        add_op(0, {$urandom, $urandom});
        add_op(1, {$urandom, $urandom});
        drive_reqs();
        repeat (12) cycle();
        check("t3_grants_held", 128'(n_grants), 128'(4));
        check("t3_inflight_full", 128'(inflight), 128'(4));
        check("t3_stalled", 128'(bus_if.req_get), 128'(0));
        post_hold = 1'b0;
        drain("t3");
        check("t3_grants", 128'(n_grants), 128'(6));
        check("t3_grant5", 128'(grant_log[4]), 128'(0));
        check("t3_grant6", 128'(grant_log[5]), 128'(1));

        // T4 requester 1 withholds rsp_get
        apply_reset();
        rsp_mask = 4'b1101;
        add_op(1, 64'h0000_0003_8000_0000);
        add_op(2, 64'hFFFF_FFFE_4000_0000);
        drive_reqs();
        for (int i = 0; i < 20 && bus_if.rsp_avail !== 4'b0010; i++) cycle();
        check("t4_owner", 128'(bus_if.rsp_avail), 128'(4'b0010));
        held = bus_if.rsp_data;
        for (int i = 0; i < 10; i++) begin
            cycle();
            check("t4_post_get", 128'(bus_if.cvt_post_get), 128'(0));
            check("t4_hold", 128'(bus_if.rsp_data), 128'(held));
        end
        rsp_mask = 4'b1111;
        cycle();
        check("t4_next", 128'(bus_if.rsp_avail), 128'(4'b0100));
        drain("t4");

        // T5 zero and negative operands
        apply_reset();
        add_op(2, 64'h0);
        add_op(3, 64'hFFFF_FFFF_0000_0000);
        drive_reqs();
        drain("t5");
        check("t5_zero", 128'(last_lane_data[2]), 128'(64'h0));
        check("t5_neg", 128'(last_lane_data[3]), 128'(64'hBFF0_0000_0000_0000));

        // Orphan result: converter presents data with no tag outstanding
        inject_post = 1'b1;
        #1;
        check("orphan_post_get", 128'(bus_if.cvt_post_get), 128'(0));
        @(posedge clk);
        #1;
        inject_post = 1'b0;
        check("orphan_err", 128'(err), 128'(1));
        @(posedge clk);
        #1;
        check("orphan_err_sticky", 128'(err), 128'(1));

        // T6 asynchronous reset with work in flight
        rsp_mask = 4'b0000;
        for (int l = 0; l < 4; l++) add_op(l, {$urandom, $urandom});
        drive_reqs();
        for (int i = 0; i < 30 && !(inflight == 3'd3 && bus_if.rsp_avail != 4'b0); i++) cycle();
        check("t6_inflight", 128'(inflight), 128'(3));
        check("t6_rsp_vld", 128'(bus_if.rsp_avail != 4'b0), 128'(1));
        rst_n = 1'b0;
        #2;
        check_reset("t6");
        clear_tb();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        add_op(1, 64'h0000_0002_0000_0000);
        drive_reqs();
        drain("t6");
        check("t6_value", 128'(last_lane_data[1]), 128'(64'h4000_0000_0000_0000));
        check("t6_err", 128'(err), 128'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
